// File: rtl/ibus_arb_pkg.sv
// rtl/ibus_arb_pkg.sv - shared CPU package: internal-bus owner and request record types
package ibus_arb_pkg;

   // Current internal-bus owner; encoding is visible on the OWNER port
   typedef enum logic [1:0] {
      IO_NONE = 2'b00,
      IO_M0   = 2'b01,
      IO_M1   = 2'b10
   } IbusOwner_t;

   // One master's request as seen by the slave-side mux
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] di;
      logic [3:0]  ba;
      logic        we;
      logic        req;
   } IbusReq_t;

   localparam int unsigned DCNT_W = 3;

endpackage

// File: rtl/ibus_arb_pick.sv
// rtl/ibus_arb_pick.sv - combinational owner pick: DMAC priority unless the fairness limit is hit
module ibus_arb_pick
   import ibus_arb_pkg::*;
(
   input  logic       m0_req,
   input  logic       m1_req,
   input  logic       limit,
   output IbusOwner_t owner
);

   // DMAC wins a tie; the CPU wins a tie once the DMAC has used up its fair share
   always_comb begin
      owner = IO_NONE;
      if (m0_req && (!m1_req || limit)) begin
         owner = IO_M0;
      end else if (m1_req) begin
         owner = IO_M1;
      end
   end

endmodule

// File: rtl/ibus_arb.sv
// rtl/ibus_arb.sv - CPU/DMAC internal-bus arbiter; IBUS_ARB_FAIR_EN compiles in the DMAC fairness counter
module ibus_arb
   import ibus_arb_pkg::*;
#(
   parameter int unsigned FAIR_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        RES_N,
   input  logic [31:0] M0_A,
   input  logic [31:0] M0_DI,
   input  logic [3:0]  M0_BA,
   input  logic        M0_WE,
   input  logic        M0_REQ,
   input  logic        M0_LOCK,
   input  logic [31:0] M1_A,
   input  logic [31:0] M1_DI,
   input  logic [3:0]  M1_BA,
   input  logic        M1_WE,
   input  logic        M1_REQ,
   input  logic        M1_BURST,
   output logic [31:0] M0_DO,
   output logic        M0_BUSY,
   output logic [31:0] M1_DO,
   output logic        M1_BUSY,
   output logic [31:0] S_A,
   output logic [31:0] S_DO,
   output logic [3:0]  S_BA,
   output logic        S_WE,
   output logic        S_REQ,
   output logic        S_LOCK,
   input  logic [31:0] S_DI,
   input  logic        S_BUSY,
   output logic [1:0]  OWNER
);

   if (FAIR_LIMIT < 1 || FAIR_LIMIT > 7) begin : g_limit_range
      $error("ibus_arb: FAIR_LIMIT must be in 1..7");
   end

   IbusOwner_t owner_q, owner_d, pick_owner;
   IbusReq_t   m0_r, m1_r, own_req;
   logic       done;
   logic       limit;

   assign m0_r = '{a: M0_A, di: M0_DI, ba: M0_BA, we: M0_WE, req: M0_REQ};
   assign m1_r = '{a: M1_A, di: M1_DI, ba: M1_BA, we: M1_WE, req: M1_REQ};

   // Slave-side mux: only the owner reaches the slave, IDLE drives all zeros
   always_comb begin
      own_req = '0;
      S_LOCK  = 1'b0;
      case (owner_q)
         IO_M0: begin
            own_req = m0_r;
            S_LOCK  = M0_LOCK;
         end
         IO_M1:   own_req = m1_r;
         default: own_req = '0;
      endcase
   end

   assign S_A   = own_req.a;
   assign S_DO  = own_req.di;
   assign S_BA  = own_req.ba;
   assign S_WE  = own_req.we;
   assign S_REQ = own_req.req;

   assign M0_DO   = S_DI;
   assign M1_DO   = S_DI;
   assign M0_BUSY = M0_REQ && (owner_q != IO_M0 || S_BUSY);
   assign M1_BUSY = M1_REQ && (owner_q != IO_M1 || S_BUSY);
   assign OWNER   = owner_q;

   // The owner's transfer is accepted on this edge
   assign done = CE_R && own_req.req && !S_BUSY;

`ifdef IBUS_ARB_FAIR_EN
   localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic              m1_done;

   assign m1_done = done && (owner_q == IO_M1);
   // The completion that brings DCNT to the limit already hands the bus to the waiting CPU
   assign limit   = M0_REQ && (({1'b0, dcnt_q} + {3'b000, m1_done}) >= LIMIT);

   // DCNT counts DMAC completions while the CPU waits, cleared once the CPU gets the bus
   always_comb begin
      dcnt_d = dcnt_q;
      if (!M0_REQ || owner_d == IO_M0) begin
         dcnt_d = '0;
      end else if (m1_done && dcnt_q != 3'd7) begin
         dcnt_d = dcnt_q + 3'd1;
      end
   end

   // DCNT register, updated only on CE_R, cleared by either reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dcnt_q <= '0;
      end else if (!RES_N) begin
         dcnt_q <= '0;
      end else if (CE_R) begin
         dcnt_q <= dcnt_d;
      end
   end
`else
   assign limit = 1'b0;
`endif

   ibus_arb_pick u_pick (
      .m0_req (M0_REQ),
      .m1_req (M1_REQ),
      .limit  (limit),
      .owner  (pick_owner)
   );

   // Next owner: hold through lock/burst, re-arbitrate on completion, release on dropped request
   always_comb begin
      owner_d = owner_q;
      case (owner_q)
         IO_M0: begin
            if (done) begin
               owner_d = M0_LOCK ? IO_M0 : pick_owner;
            end else if (!M0_REQ && !M0_LOCK) begin
               owner_d = IO_NONE;
            end
         end
         IO_M1: begin
            if (done) begin
               owner_d = (M1_BURST && !limit) ? IO_M1 : pick_owner;
            end else if (!M1_REQ && !M1_BURST) begin
               owner_d = IO_NONE;
            end
         end
         default: owner_d = pick_owner;
      endcase
   end

   // Owner register; soft reset wins over a simultaneous completion
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         owner_q <= IO_NONE;
      end else if (!RES_N) begin
         owner_q <= IO_NONE;
      end else if (CE_R) begin
         owner_q <= owner_d;
      end
   end

endmodule

// File: doc/ibus_arb.md
# ibus_arb

Two-master internal-bus arbiter placed between the CPU core, the DMA controller and the bus state controller's internal-bus slave port. It shares the single internal bus between CPU (M0) and DMAC (M1). Ownership is held across CPU locked sequences (TAS read-modify-write) and DMAC bursts. Requests are muxed onto one slave port, and the non-owner is stalled through its BUSY line.

## Interface
- FAIR_LIMIT, 4: consecutive DMAC transfers allowed while the CPU waits. Legal range 1..7.
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE_R  in  1  rising-phase clock enable; all state updates occur only on CE_R
- RES_N  in  1  soft reset, synchronous, sampled every CLK
- M0_A / M1_A  in  32  master address
- M0_DI / M1_DI  in  32  master write data
- M0_BA / M1_BA  in  4  byte enables
- M0_WE / M1_WE  in  1  write strobe
- M0_REQ / M1_REQ  in  1  access request
- M0_LOCK  in  1  CPU locked sequence; holds ownership
- M1_BURST  in  1  DMAC burst; holds ownership
- M0_DO / M1_DO  out  32  read data, both driven from S_DI
- M0_BUSY / M1_BUSY  out  1  stall to master
- S_A  out  32  slave address
- S_DO  out  32  slave write data
- S_BA  out  4  slave byte enables
- S_WE  out  1  slave write strobe
- S_REQ  out  1  slave request
- S_LOCK  out  1  slave lock
- S_DI  in  32  slave read data
- S_BUSY  in  1  slave stall
- OWNER  out  2  current owner: 00 none, 01 M0, 10 M1

## Operation
- State register OWNER has three states: IDLE (00), OWN_M0 (01), OWN_M1 (10).
- Slave-side outputs are a combinational mux selected by OWNER.
  - In IDLE: S_REQ=0, S_WE=0, S_LOCK=0, S_A=0, S_DO=0, S_BA=0.
  - S_REQ = owner's REQ. S_LOCK = M0_LOCK while OWN_M0, otherwise 0.
- Mx_BUSY = Mx_REQ & (OWNER != x | S_BUSY).
- Completion edge: a CE_R cycle with S_REQ=1 and S_BUSY=0. The owner's transfer is accepted there.
- IDLE on CE_R:
  - Only one REQ asserted: grant that master.
  - Both asserted: M1 wins unless the fairness rule says otherwise.
  - Neither asserted: stay in IDLE.
- OWN_x on a completion edge:
  - Hold ownership if the owner's hold signal (M0_LOCK or M1_BURST) is still 1.
  - Otherwise re-arbitrate in the same edge using the IDLE rules. The result may be the same owner, the other master, or IDLE.
- OWN_x when the owner drops REQ without a completion edge: on CE_R go to IDLE, unless the hold signal is still 1.
- Fairness counter DCNT (3 bits) counts M1 completion edges while M0_REQ=1.
  - When DCNT reaches FAIR_LIMIT, M1_BURST is ignored at the next completion edge and M0 wins.
  - DCNT clears on any M0 grant and whenever M0_REQ=0.
- RES_N=0 forces IDLE and DCNT=0 at the next CLK, even mid-transfer. The slave is responsible for abandoning its own cycle.
- A simultaneous RES_N=0 and completion edge resolves as the reset.

## Timing
- Reset values:
  - OWNER=00, DCNT=0.
  - All S_* outputs 0.
  - Mx_BUSY = Mx_REQ.
  - Mx_DO = S_DI.
- Grant latency from IDLE: one CE_R. S_REQ rises in the cycle after the granting CE_R.
- Back-to-back handoff adds no idle cycle: the new owner's S_REQ is valid immediately after the completion edge.
- Read data is valid on Mx_DO at the owner's completion edge. It is meaningful only for the owner.
- Inputs are sampled only on CE_R. Cycles with CE_R=0 change no state.

## Configuration
- IBUS_ARB_FAIR_EN defined: DCNT and the FAIR_LIMIT override are compiled in.
- IBUS_ARB_FAIR_EN undefined: DCNT is removed and M1 keeps the bus for the entire burst. FAIR_LIMIT is then ignored.

## Structure
- These belong in the shared CPU package: the owner typedef IbusOwner_t {IO_NONE, IO_M0, IO_M1}, and the IBUS request record typedef (A, DI, BA, WE, REQ).
- One sub-module, ibus_arb_pick: a combinational priority/fairness decision. Inputs are the two REQs and the limit-reached flag; output is the next owner.

## Test plan
- CPU only: M0_REQ=1, M0_A=0x0000_0100, read; S_BUSY low after 2 CE_R → OWNER=01 after 1 CE_R, M0_BUSY drops on the completion edge, M0_DO = S_DI = 0x1234_5678.
- Simultaneous requests, no hold → M1 granted first. On M1's completion edge OWNER=01 with no IDLE gap, and M0_BUSY=1 until then.
- CPU TAS: M0_LOCK=1 across read and write, M1_REQ=1 throughout → M1_BUSY stays 1 for both transfers. S_LOCK=1. M1 is granted only at the edge where M0_LOCK=0.
- FAIR_EN build, FAIR_LIMIT=4, M1_BURST=1 with M0_REQ pending → exactly 4 M1 completions, then OWNER=01. After the M0 completion, M1 regains the bus.
- Non-FAIR build, same stimulus → M1 keeps the bus until M1_BURST=0.
- RES_N pulsed low while OWN_M1 with S_BUSY=1 → OWNER=00 and S_REQ=0 next CLK. Asynchronous RST_N gives the same result immediately.
